// File: rtl/time_ascii_sender_pkg.sv
// rtl/time_ascii_sender_pkg.sv - shared constants, state encoding and field ranges for the time ASCII sender
package time_ascii_sender_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int HOUR_MSB = 23;
  localparam int HOUR_LSB = 19;
  localparam int MIN_MSB  = 18;
  localparam int MIN_LSB  = 13;
  localparam int SEC_MSB  = 12;
  localparam int SEC_LSB  = 7;
  localparam int CS_MSB   = 6;
  localparam int CS_LSB   = 0;

  localparam int IDX_W = 4;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ASCII_0 + {4'd0, d};
  endfunction

endpackage

// File: rtl/time_ascii_sender_bin2bcd_2digit.sv
// rtl/time_ascii_sender_bin2bcd_2digit.sv - 7-bit binary to two BCD digits of (value mod 100)
module bin2bcd_2digit (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [6:0] v;

  // Input never exceeds 127, so one conditional subtract implements mod 100.
  assign v    = (bin >= 7'd100) ? (bin - 7'd100) : bin;
  assign tens = 4'(v / 7'd10);
  assign ones = 4'(v % 7'd10);

endmodule

// File: rtl/time_ascii_sender.sv
// rtl/time_ascii_sender.sv - serialises a time snapshot as "HH:MM:SS.CC[CR LF]" over a valid/ready byte stream
module time_ascii_sender
  import time_ascii_sender_pkg::*;
#(
  parameter bit ADD_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_send,
  input  logic [23:0] i_time_data,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic        o_done
);

  localparam int FRAME_LEN = ADD_CRLF ? 13 : 11;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t             state;
  logic [23:0]        snapshot;
  logic [IDX_W-1:0]   index;
  logic [23:0]        src;
  logic [IDX_W-1:0]   next_idx;
  logic [7:0]         next_byte;
  logic [3:0]         h1, h0, m1, m0, s1, s0, c1, c0;

  // In IDLE the digits come straight from the input so byte 0 is ready the cycle after acceptance.
  assign src      = (state == ST_IDLE) ? i_time_data : snapshot;
  assign next_idx = (state == ST_IDLE) ? '0 : index + 1'b1;

  bin2bcd_2digit u_hour (.bin({2'b00, src[HOUR_MSB:HOUR_LSB]}), .tens(h1), .ones(h0));
  bin2bcd_2digit u_min  (.bin({1'b0, src[MIN_MSB:MIN_LSB]}),    .tens(m1), .ones(m0));
  bin2bcd_2digit u_sec  (.bin({1'b0, src[SEC_MSB:SEC_LSB]}),    .tens(s1), .ones(s0));
  bin2bcd_2digit u_cs   (.bin(src[CS_MSB:CS_LSB]),              .tens(c1), .ones(c0));

  always_comb begin
    next_byte = 8'h00;
    case (next_idx)
      4'd0:    next_byte = ascii_digit(h1);
      4'd1:    next_byte = ascii_digit(h0);
      4'd2:    next_byte = ASCII_COLON;
      4'd3:    next_byte = ascii_digit(m1);
      4'd4:    next_byte = ascii_digit(m0);
      4'd5:    next_byte = ASCII_COLON;
      4'd6:    next_byte = ascii_digit(s1);
      4'd7:    next_byte = ascii_digit(s0);
      4'd8:    next_byte = ASCII_DOT;
      4'd9:    next_byte = ascii_digit(c1);
      4'd10:   next_byte = ascii_digit(c0);
      4'd11:   next_byte = ASCII_CR;
      4'd12:   next_byte = ASCII_LF;
      default: next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      snapshot   <= '0;
      index      <= '0;
      o_tx_data  <= 8'h00;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_done <= 1'b0;
          if (i_send) begin
            snapshot   <= i_time_data;
            index      <= '0;
            o_tx_data  <= next_byte;
            o_tx_valid <= 1'b1;
            o_busy     <= 1'b1;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (i_tx_ready) begin
            if (index == LAST_IDX) begin
              o_tx_valid <= 1'b0;
              o_tx_data  <= 8'h00;
              o_done     <= 1'b1;
              state      <= ST_DONE;
            end else begin
              index     <= next_idx;
              o_tx_data <= next_byte;
            end
          end
        end
        ST_DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          o_tx_valid <= 1'b0;
          o_busy     <= 1'b0;
          o_done     <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_ascii_sender.sv
// tb/tb_time_ascii_sender.sv - randomized self-checking bench for time_ascii_sender with both frame lengths
module tb_time_ascii_sender;

  logic        clk = 1'b0;
  logic        reset;
  logic        send13, send11;
  logic [23:0] time13, time11;
  logic        ready13, ready11;
  logic [7:0]  data13, data11;
  logic        valid13, valid11, busy13, busy11, done13, done11;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  time_ascii_sender #(.ADD_CRLF(1'b1)) dut (
    .clk(clk), .reset(reset), .i_send(send13), .i_time_data(time13),
    .o_tx_data(data13), .o_tx_valid(valid13), .i_tx_ready(ready13),
    .o_busy(busy13), .o_done(done13)
  );

  time_ascii_sender #(.ADD_CRLF(1'b0)) dut11 (
    .clk(clk), .reset(reset), .i_send(send11), .i_time_data(time11),
    .o_tx_data(data11), .o_tx_valid(valid11), .i_tx_ready(ready11),
    .o_busy(busy11), .o_done(done11)
  );

  function automatic logic [23:0] pack(input int h, input int m, input int s, input int c);
    return {5'(h), 6'(m), 6'(s), 7'(c)};
  endfunction

  // Reference frame straight from the textual format rules.
  function automatic void build_exp(input logic [23:0] t, input bit crlf);
    int f[4];
    f[0] = int'(t[23:19]);
    f[1] = int'(t[18:13]);
    f[2] = int'(t[12:7]);
    f[3] = int'(t[6:0]);
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(48 + (f[i] % 100) / 10));
      exp_q.push_back(8'(48 + (f[i] % 100) % 10));
      if (i < 2) exp_q.push_back(8'h3A);
      else if (i == 2) exp_q.push_back(8'h2E);
    end
    if (crlf) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  task automatic set_in(input bit sel, input logic s, input logic r);
    if (sel) begin send11 = s; ready11 = r; end
    else     begin send13 = s; ready13 = r; end
  endtask

  task automatic set_time(input bit sel, input logic [23:0] t);
    if (sel) time11 = t; else time13 = t;
  endtask

  task automatic run_frame(input bit sel, input logic [23:0] t, input int pct, input bit disturb);
    int       flen;
    logic     v, dn, bz, r, pv, pr, seen_done, disturbed, extra;
    logic [7:0] d, pd;
    int       done_cyc;
    flen = sel ? 11 : 13;
    build_exp(t, !sel);
    got_q.delete();
    @(negedge clk);
    set_time(sel, t);
    set_in(sel, 1'b1, 1'b0);
    @(negedge clk);
    set_in(sel, 1'b0, 1'b0);
    v = sel ? valid11 : valid13;
    total++;
    assert (v === 1'b1) else begin bad++; $error("FAIL accept_latency got=%b exp=1", v); end
    seen_done = 0; disturbed = 0; pv = 0; pr = 0; pd = 8'h00; r = 0; done_cyc = -1;
    for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      v  = sel ? valid11 : valid13;
      d  = sel ? data11  : data13;
      dn = sel ? done11  : done13;
      set_in(sel, 1'b0, r);
      if (pv && !pr) begin
        total++;
        assert (v === 1'b1 && d === pd)
          else begin bad++; $error("FAIL stall_hold got=%b/%h exp=1/%h", v, d, pd); end
      end
      if (dn === 1'b1) begin
        seen_done = 1;
        done_cyc  = cyc;
        total++;
        assert (v === 1'b0) else begin bad++; $error("FAIL valid_in_done got=%b exp=0", v); end
        r = 0;
        set_in(sel, disturb, 1'b0);
        if (disturb) set_time(sel, pack(9, 9, 9, 9));
      end else begin
        r = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
        if (disturb && !disturbed && got_q.size() == 4) begin
          disturbed = 1;
          set_time(sel, pack(23, 59, 59, 99));
          set_in(sel, 1'b1, r);
        end else begin
          set_in(sel, 1'b0, r);
        end
        if (v === 1'b1 && r) got_q.push_back(d);
      end
      pv = v; pr = r; pd = d;
    end
    total++;
    assert (seen_done) else begin bad++; $error("FAIL done_timeout got=0 exp=1"); end
    if (pct >= 100) begin
      total++;
      assert (done_cyc == flen) else begin bad++; $error("FAIL done_cycle got=%0d exp=%0d", done_cyc, flen); end
    end
    total++;
    assert (got_q.size() == exp_q.size())
      else begin bad++; $error("FAIL frame_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      assert (got_q[i] === exp_q[i])
        else begin bad++; $error("FAIL byte%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    @(negedge clk);
    set_in(sel, 1'b0, 1'b0);
    dn = sel ? done11 : done13;
    bz = sel ? busy11 : busy13;
    total++;
    assert (dn === 1'b0 && bz === 1'b0)
      else begin bad++; $error("FAIL after_done got=%b%b exp=00", dn, bz); end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if ((sel ? valid11 : valid13) !== 1'b0) extra = 1;
    end
    total++;
    assert (extra == 0) else begin bad++; $error("FAIL no_second_frame got=%b exp=0", extra); end
  endtask

  initial begin
    reset = 1'b1;
    send13 = 0; send11 = 0; ready13 = 0; ready11 = 0;
    time13 = '0; time11 = '0;
    #3 reset = 1'b0;
    #1;
    total++;
    assert (valid13 === 1'b0 && busy13 === 1'b0 && done13 === 1'b0 && data13 === 8'h00)
      else begin bad++; $error("FAIL reset_state got=%b%b%b/%h exp=000/00", valid13, busy13, done13, data13); end
    total++;
    assert (valid11 === 1'b0 && busy11 === 1'b0 && done11 === 1'b0 && data11 === 8'h00)
      else begin bad++; $error("FAIL reset_state11 got=%b%b%b/%h exp=000/00", valid11, busy11, done11, data11); end
    repeat (3) @(negedge clk);
    reset = 1'b1;

    run_frame(1'b0, pack(12, 34, 56, 78), 100, 1'b0);
    run_frame(1'b0, pack(12, 34, 56, 78), 50, 1'b0);
    run_frame(1'b0, pack(12, 34, 56, 78), 70, 1'b1);
    run_frame(1'b0, pack(0, 0, 0, 0), 100, 1'b0);
    run_frame(1'b0, pack(0, 0, 0, 105), 100, 1'b0);
    run_frame(1'b1, pack(1, 2, 3, 4), 100, 1'b0);
    run_frame(1'b1, pack(31, 63, 63, 127), 40, 1'b1);

    // Abort a frame after five transfers.
    @(negedge clk);
    time13 = pack(7, 8, 9, 10);
    send13 = 1'b1;
    ready13 = 1'b1;
    @(negedge clk);
    send13 = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    assert (valid13 === 1'b0 && busy13 === 1'b0 && done13 === 1'b0 && data13 === 8'h00)
      else begin bad++; $error("FAIL reset_abort got=%b%b%b/%h exp=000/00", valid13, busy13, done13, data13); end
    @(negedge clk);
    ready13 = 1'b0;
    reset = 1'b1;
    run_frame(1'b0, pack(7, 8, 9, 10), 100, 1'b0);

    for (int k = 0; k < 6; k++) begin
      run_frame(k[0], 24'($urandom), int'($urandom_range(25, 100)), k[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_ascii_sender.md
# time_ascii_sender

Serialises a snapshot of the 24-bit time word produced by the watch/stopwatch datapath into the ASCII frame "HH:MM:SS.CC" plus optional CR LF. It emits one byte at a time over a valid/ready handshake to the UART transmitter. It sits directly downstream of the time-data mux and directly upstream of the UART TX byte interface.

## Interface
- ADD_CRLF, 1: 1 appends 0x0D 0x0A, giving a 13-byte frame; 0 gives an 11-byte frame.
- clk  input  1  system clock (100 MHz).
- reset  input  1  asynchronous, active-low reset (0 = reset).
- i_send  input  1  single-cycle request to transmit the current time.
- i_time_data  input  24  packed time: hour[23:19], min[18:13], sec[12:7], msec[6:0] (centiseconds).
- o_tx_data  output  8  current ASCII byte.
- o_tx_valid  output  1  o_tx_data holds a byte to transfer.
- i_tx_ready  input  1  UART TX can accept a byte (e.g. !tx_busy).
- o_busy  output  1  a frame is in progress (state ≠ IDLE).
- o_done  output  1  one-cycle pulse after the last byte transfers.

## Operation
- **FSM states:** IDLE, SEND, DONE.
- **IDLE:**
  - o_tx_valid=0.
  - On i_send=1: register i_time_data into the snapshot, clear the byte index to 0, go to SEND.
- **SEND:**
  - o_tx_valid=1; o_tx_data = byte[index] built from the snapshot.
  - On a clock edge with o_tx_valid & i_tx_ready, the byte transfers:
    - If index = FRAME_LEN-1, go to DONE.
    - Otherwise index+1.
- **DONE:**
  - o_done=1 for exactly one cycle, then IDLE.
- **Byte order:** H1 H0 ':' M1 M0 ':' S1 S0 '.' C1 C0 [0x0D 0x0A].
- **Digit encoding:** each digit is 0x30 + BCD digit.
- **Two-digit conversion:** each field is converted as v mod 100 → tens = (v mod 100)/10, ones = (v mod 100) mod 10.
  - Only msec (max 127) can exceed 99; e.g. 105 displays as "05".
- **Separator constants:** ':' = 0x3A, '.' = 0x2E.
- **Busy requests:** i_send while busy (SEND or DONE) is ignored. There is no queueing, and the snapshot is unchanged.
- **Stable snapshot:** the snapshot is frozen for the whole frame; changes on i_time_data after acceptance do not affect the frame.
- **Reset:** reset=0 at any time aborts the frame.
  - State becomes IDLE; index, snapshot, o_tx_valid, o_busy and o_done all go to 0.
  - o_tx_data resets to 0x00.

## Timing
- **Request acceptance:** i_send high in IDLE at edge N → o_tx_valid=1 with byte 0 from cycle N+1 (one cycle latency).
- **Handshake rule:** while o_tx_valid=1 and i_tx_ready=0, o_tx_data and o_tx_valid hold stable. Valid is never withdrawn mid-frame.
- **Back-to-back throughput:** with i_tx_ready tied 1, one byte transfers per cycle. The frame occupies FRAME_LEN cycles in SEND, then 1 cycle in DONE.
- **Frame completion:** the last transfer at edge K → o_done=1 and o_tx_valid=0 during cycle K+1; IDLE from K+2.
  - i_send during DONE is ignored.
  - The earliest new acceptance is at edge K+2.
- **Output register:** o_tx_data is driven from a registered mux on the snapshot and index. It is glitch-free and carries no combinational path from i_tx_ready.
- **Async reset:** takes effect immediately. Deassertion is synchronous to clk through an existing reset synchroniser upstream.

## Structure
- **Shared package/header:**
  - ASCII constants: ASCII_0=0x30, ASCII_COLON, ASCII_DOT, ASCII_CR, ASCII_LF.
  - FSM state encodings.
  - Field bit ranges of the packed time word.
- **FRAME_LEN:** a localparam derived from ADD_CRLF (11 or 13); index width $clog2(13)=4.
- **Sub-module:** bin2bcd_2digit, a combinational 7-bit → two 4-bit BCD digits applying the mod-100 rule, instantiated four times (hour, min, sec, msec).

## Test plan
- **Nominal frame:** time 12:34:56.78, i_tx_ready=1, i_send pulse → bytes 31 32 3A 33 34 3A 35 36 2E 37 38 0D 0A on 13 consecutive cycles, then o_done pulse.
- **Backpressure:** i_tx_ready toggles pseudo-randomly → no byte dropped or duplicated, o_tx_data stable while stalled, same 13-byte sequence.
- **Busy and snapshot:** i_send re-pulsed mid-frame, and i_time_data changed to 23:59:59.99 mid-frame → the frame still carries 12:34:56.78 and no second frame follows.
- **Zero and overflow values:** time 00:00:00.00 → "00:00:00.00\r\n"; msec=105 → C1C0 = 30 35.
- **Reset mid-frame:** reset=0 after byte 5 → o_tx_valid, o_busy, o_done = 0 immediately. After release, a new i_send produces a complete fresh frame from byte 0.
- **No CR LF:** ADD_CRLF=0, time 01:02:03.04 → 11 bytes ending 30 34, o_done on the following cycle.
